// File: rtl/wb_fm_packer_pkg.sv
// Shared constants and FSM encoding for the write-back FM/guard packer.
package wb_fm_packer_pkg;

    localparam int unsigned FM_WORD_BYTES = 8;
    localparam int unsigned FM_ADDR_W     = 12;
    localparam int unsigned GUARD_GROUPS  = 8;
    localparam int unsigned GUARD_ADDR_W  = 10;

    typedef enum logic [1:0] {
        PK_IDLE,
        PK_RUN,
        PK_FLUSH,
        PK_DONE
    } pk_state_t;

endpackage

// File: rtl/wb_fm_packer_if.sv
// Write-back side stream/control inputs and FM/guard buffer write ports of the packer.
interface wb_fm_packer_if #(
    parameter int unsigned FM_WORD_BYTES = wb_fm_packer_pkg::FM_WORD_BYTES,
    parameter int unsigned FM_ADDR_W     = wb_fm_packer_pkg::FM_ADDR_W,
    parameter int unsigned GUARD_GROUPS  = wb_fm_packer_pkg::GUARD_GROUPS,
    parameter int unsigned GUARD_ADDR_W  = wb_fm_packer_pkg::GUARD_ADDR_W
);

    logic                        start_i;
    logic [FM_ADDR_W-1:0]        fm_base_i;
    logic [GUARD_ADDR_W-1:0]     guard_base_i;
    logic [7:0]                  data_i;
    logic                        data_i_valid;
    logic                        bit_mode_i;
    logic [5:0]                  guard_i;
    logic                        guard_i_valid;
    logic                        finish_i;

    logic                        fm_wr_en;
    logic [FM_ADDR_W-1:0]        fm_wr_addr;
    logic [8*FM_WORD_BYTES-1:0]  fm_wr_data;
    logic [FM_WORD_BYTES-1:0]    fm_wr_mask;
    logic                        guard_wr_en;
    logic [GUARD_ADDR_W-1:0]     guard_wr_addr;
    logic [6*GUARD_GROUPS-1:0]   guard_wr_data;
    logic                        done_o;

    // Write-back stage / layer controller side
    modport master (
        output start_i, fm_base_i, guard_base_i, data_i, data_i_valid, bit_mode_i,
               guard_i, guard_i_valid, finish_i,
        input  fm_wr_en, fm_wr_addr, fm_wr_data, fm_wr_mask,
               guard_wr_en, guard_wr_addr, guard_wr_data, done_o
    );

    // Packer side
    modport slave (
        input  start_i, fm_base_i, guard_base_i, data_i, data_i_valid, bit_mode_i,
               guard_i, guard_i_valid, finish_i,
        output fm_wr_en, fm_wr_addr, fm_wr_data, fm_wr_mask,
               guard_wr_en, guard_wr_addr, guard_wr_data, done_o
    );

endinterface

// File: rtl/wb_fm_packer_guard.sv
// Guard-map packer: gathers 6-bit guard maps into guard-buffer words and flushes partial words.
module wb_guard_packer #(
    parameter int unsigned GUARD_GROUPS = wb_fm_packer_pkg::GUARD_GROUPS,
    parameter int unsigned GUARD_ADDR_W = wb_fm_packer_pkg::GUARD_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load_i,
    input  logic [GUARD_ADDR_W-1:0]   base_i,
    input  logic                      accept_i,
    input  logic [5:0]                guard_i,
    input  logic                      flush_i,
    output logic                      wr_en_o,
    output logic [GUARD_ADDR_W-1:0]   wr_addr_o,
    output logic [6*GUARD_GROUPS-1:0] wr_data_o
);

    localparam int unsigned GROUP_W = $clog2(GUARD_GROUPS);
    typedef logic [GROUP_W-1:0]      group_t;
    typedef logic [GUARD_ADDR_W-1:0] gaddr_t;
    localparam group_t LAST_GROUP = group_t'(GUARD_GROUPS - 1);

    group_t                    group_q, group_d;
    logic [6*GUARD_GROUPS-1:0] acc_q, acc_d;
    gaddr_t                    addr_q, addr_d;
    logic                      wr_en_q, wr_en_d;
    gaddr_t                    wr_addr_q, wr_addr_d;
    logic [6*GUARD_GROUPS-1:0] wr_data_q, wr_data_d;

    // Register accumulator, address counter and write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            group_q   <= '0;
            acc_q     <= '0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            group_q   <= group_d;
            acc_q     <= acc_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Place guard maps into groups; emit full words, or the partial word on flush
    always_comb begin
        group_d   = group_q;
        acc_d     = acc_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (load_i) begin
            addr_d  = base_i;
            group_d = '0;
            acc_d   = '0;
        end

        if (accept_i) begin
            acc_d[32'(group_q)*6 +: 6] = guard_i;
            if (group_q == LAST_GROUP) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = acc_d;
                addr_d    = addr_q + gaddr_t'(1);
                acc_d     = '0;
                group_d   = '0;
            end else begin
                group_d = group_q + group_t'(1);
            end
        end

        if (flush_i && (group_q != '0)) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = acc_q;
            addr_d    = addr_q + gaddr_t'(1);
            acc_d     = '0;
            group_d   = '0;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;

endmodule

// File: rtl/wb_fm_packer.sv
// Packs write-back bytes / 4-bit diff pairs into FM-buffer words and guard maps into guard words.
module wb_fm_packer #(
    parameter int unsigned FM_WORD_BYTES = wb_fm_packer_pkg::FM_WORD_BYTES,
    parameter int unsigned FM_ADDR_W     = wb_fm_packer_pkg::FM_ADDR_W,
    parameter int unsigned GUARD_GROUPS  = wb_fm_packer_pkg::GUARD_GROUPS,
    parameter int unsigned GUARD_ADDR_W  = wb_fm_packer_pkg::GUARD_ADDR_W
) (
    input  logic          clk,
    input  logic          rst,
    wb_fm_packer_if.slave bus
);

    import wb_fm_packer_pkg::*;

    localparam int unsigned LANE_W    = $clog2(FM_WORD_BYTES);
    localparam int unsigned FM_DATA_W = 8 * FM_WORD_BYTES;
    typedef logic [LANE_W-1:0]    lane_t;
    typedef logic [FM_ADDR_W-1:0] fm_addr_t;
    localparam lane_t LAST_LANE = lane_t'(FM_WORD_BYTES - 1);

    pk_state_t                state_q, state_d;
    lane_t                    lane_q, lane_d;
    logic [FM_DATA_W-1:0]     word_q, word_d;
    logic [FM_WORD_BYTES-1:0] used_q, used_d;
    logic [3:0]               pend_q, pend_d;
    logic                     pend_v_q, pend_v_d;
    fm_addr_t                 addr_q, addr_d;
    logic                     fm_wr_en_q, fm_wr_en_d;
    fm_addr_t                 fm_wr_addr_q, fm_wr_addr_d;
    logic [FM_DATA_W-1:0]     fm_wr_data_q, fm_wr_data_d;
    logic [FM_WORD_BYTES-1:0] fm_wr_mask_q, fm_wr_mask_d;

    logic                     in_idle, in_run, in_flush, done;
    logic [1:0]               put;
    logic [7:0]               put_byte [2];
    logic                     emit;
    logic [FM_DATA_W-1:0]     emit_data;
    logic [FM_WORD_BYTES-1:0] emit_mask;

    assign in_idle  = (state_q == PK_IDLE);
    assign in_run   = (state_q == PK_RUN);
    assign in_flush = (state_q == PK_FLUSH);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= PK_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: layer start, finish, one-cycle flush and done
    always_comb begin
        state_d = state_q;
        case (state_q)
            PK_IDLE:  if (bus.start_i)  state_d = PK_RUN;
            PK_RUN:   if (bus.finish_i) state_d = PK_FLUSH;
            PK_FLUSH: state_d = PK_DONE;
            PK_DONE:  state_d = PK_IDLE;
            default:  state_d = PK_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        done = (state_q == PK_DONE);
    end

    // Byte-path registers and FM write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q       <= '0;
            word_q       <= '0;
            used_q       <= '0;
            pend_q       <= '0;
            pend_v_q     <= 1'b0;
            addr_q       <= '0;
            fm_wr_en_q   <= 1'b0;
            fm_wr_addr_q <= '0;
            fm_wr_data_q <= '0;
            fm_wr_mask_q <= '0;
        end else begin
            lane_q       <= lane_d;
            word_q       <= word_d;
            used_q       <= used_d;
            pend_q       <= pend_d;
            pend_v_q     <= pend_v_d;
            addr_q       <= addr_d;
            fm_wr_en_q   <= fm_wr_en_d;
            fm_wr_addr_q <= fm_wr_addr_d;
            fm_wr_data_q <= fm_wr_data_d;
            fm_wr_mask_q <= fm_wr_mask_d;
        end
    end

    // Byte/nibble packing. Each cycle yields up to two bytes for consecutive lanes
    // (pending nibble plus a full byte); they are placed in order so a word that
    // fills on the first one is emitted and the second starts the next word.
    always_comb begin
        lane_d       = lane_q;
        word_d       = word_q;
        used_d       = used_q;
        pend_d       = pend_q;
        pend_v_d     = pend_v_q;
        addr_d       = addr_q;
        fm_wr_en_d   = 1'b0;
        fm_wr_addr_d = fm_wr_addr_q;
        fm_wr_data_d = fm_wr_data_q;
        fm_wr_mask_d = fm_wr_mask_q;
        put          = 2'b00;
        put_byte[0]  = '0;
        put_byte[1]  = '0;
        emit         = 1'b0;
        emit_data    = '0;
        emit_mask    = '0;

        if (in_idle && bus.start_i) begin
            addr_d   = bus.fm_base_i;
            lane_d   = '0;
            word_d   = '0;
            used_d   = '0;
            pend_d   = '0;
            pend_v_d = 1'b0;
        end

        if (in_run && bus.data_i_valid) begin
            if (bus.bit_mode_i) begin
                if (pend_v_q) begin
                    put[0]      = 1'b1;
                    put_byte[0] = {bus.data_i[3:0], pend_q};
                    pend_v_d    = 1'b0;
                end else begin
                    pend_d   = bus.data_i[3:0];
                    pend_v_d = 1'b1;
                end
            end else if (pend_v_q) begin
                put         = 2'b11;
                put_byte[0] = {4'h0, pend_q};
                put_byte[1] = bus.data_i;
                pend_v_d    = 1'b0;
            end else begin
                put[0]      = 1'b1;
                put_byte[0] = bus.data_i;
            end
        end

        if (in_flush && pend_v_q) begin
            put[0]      = 1'b1;
            put_byte[0] = {4'h0, pend_q};
            pend_v_d    = 1'b0;
        end

        for (int unsigned i = 0; i < 2; i++) begin
            if (put[i]) begin
                word_d[{lane_d, 3'b000} +: 8] = put_byte[i];
                used_d[lane_d]                = 1'b1;
                if (lane_d == LAST_LANE) begin
                    emit      = 1'b1;
                    emit_data = word_d;
                    emit_mask = used_d;
                    word_d    = '0;
                    used_d    = '0;
                    lane_d    = '0;
                end else begin
                    lane_d = lane_d + lane_t'(1);
                end
            end
        end

        if (in_flush && (used_d != '0)) begin
            emit      = 1'b1;
            emit_data = word_d;
            emit_mask = used_d;
            word_d    = '0;
            used_d    = '0;
            lane_d    = '0;
        end

        if (emit) begin
            fm_wr_en_d   = 1'b1;
            fm_wr_addr_d = addr_q;
            fm_wr_data_d = emit_data;
            fm_wr_mask_d = emit_mask;
            addr_d       = addr_q + fm_addr_t'(1);
        end
    end

    wb_guard_packer #(
        .GUARD_GROUPS (GUARD_GROUPS),
        .GUARD_ADDR_W (GUARD_ADDR_W)
    ) u_guard (
        .clk       (clk),
        .rst       (rst),
        .load_i    (in_idle && bus.start_i),
        .base_i    (bus.guard_base_i),
        .accept_i  (in_run && bus.guard_i_valid),
        .guard_i   (bus.guard_i),
        .flush_i   (in_flush),
        .wr_en_o   (bus.guard_wr_en),
        .wr_addr_o (bus.guard_wr_addr),
        .wr_data_o (bus.guard_wr_data)
    );

    assign bus.fm_wr_en   = fm_wr_en_q;
    assign bus.fm_wr_addr = fm_wr_addr_q;
    assign bus.fm_wr_data = fm_wr_data_q;
    assign bus.fm_wr_mask = fm_wr_mask_q;
    assign bus.done_o     = done;

endmodule

// File: tb/tb_wb_fm_packer.sv
// Directed bench for wb_fm_packer: byte, nibble, mixed, guard, wrap and reset scenarios.
module tb_wb_fm_packer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    wb_fm_packer_if #(
        .FM_WORD_BYTES (8),
        .FM_ADDR_W     (12),
        .GUARD_GROUPS  (8),
        .GUARD_ADDR_W  (10)
    ) wbif ();

    wb_fm_packer #(
        .FM_WORD_BYTES (8),
        .FM_ADDR_W     (12),
        .GUARD_GROUPS  (8),
        .GUARD_ADDR_W  (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (wbif)
    );

    // Write monitor: records every strobed write shortly after the clock edge
    logic [11:0] fa_q [$];
    logic [63:0] fd_q [$];
    logic [7:0]  fk_q [$];
    logic [9:0]  ga_q [$];
    logic [47:0] gd_q [$];

    always @(posedge clk) begin
        #1;
        if (wbif.fm_wr_en === 1'b1) begin
            fa_q.push_back(wbif.fm_wr_addr);
            fd_q.push_back(wbif.fm_wr_data);
            fk_q.push_back(wbif.fm_wr_mask);
        end
        if (wbif.guard_wr_en === 1'b1) begin
            ga_q.push_back(wbif.guard_wr_addr);
            gd_q.push_back(wbif.guard_wr_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        fa_q.delete(); fd_q.delete(); fk_q.delete();
        ga_q.delete(); gd_q.delete();
    endtask

    task automatic do_start(input logic [11:0] fb, input logic [9:0] gb);
        wbif.start_i      = 1'b1;
        wbif.fm_base_i    = fb;
        wbif.guard_base_i = gb;
        @(negedge clk);
        wbif.start_i      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic mode, input logic fin);
        wbif.data_i       = d;
        wbif.data_i_valid = 1'b1;
        wbif.bit_mode_i   = mode;
        wbif.finish_i     = fin;
        @(negedge clk);
        wbif.data_i_valid = 1'b0;
        wbif.bit_mode_i   = 1'b0;
        wbif.finish_i     = 1'b0;
    endtask

    task automatic send_guard(input logic [5:0] g);
        wbif.guard_i       = g;
        wbif.guard_i_valid = 1'b1;
        @(negedge clk);
        wbif.guard_i_valid = 1'b0;
    endtask

    task automatic pulse_finish();
        wbif.finish_i = 1'b1;
        @(negedge clk);
        wbif.finish_i = 1'b0;
    endtask

    // Waits (bounded) for done_o, then steps once more so the FSM is back in IDLE
    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (wbif.done_o === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({wbif.fm_wr_en, wbif.fm_wr_addr, wbif.fm_wr_data, wbif.fm_wr_mask} !== '0) begin
            bad++;
            $display("FAIL reset_fm got en=%b addr=%h data=%h mask=%h want all 0",
                     wbif.fm_wr_en, wbif.fm_wr_addr, wbif.fm_wr_data, wbif.fm_wr_mask);
        end
        total++;
        if ({wbif.guard_wr_en, wbif.guard_wr_addr, wbif.guard_wr_data, wbif.done_o} !== '0) begin
            bad++;
            $display("FAIL reset_guard got en=%b addr=%h data=%h done=%b want all 0",
                     wbif.guard_wr_en, wbif.guard_wr_addr, wbif.guard_wr_data, wbif.done_o);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_8bit();
        bit seen;
        clear_mon();
        send_byte(8'hEE, 1'b0, 1'b0);  // IDLE: must be ignored
        do_start(12'h010, 10'h000);
        for (int i = 1; i <= 16; i++) begin
            send_byte(8'(i), 1'b0, 1'b0);
            if (i == 8) begin
                total++;
                if (wbif.fm_wr_en !== 1'b1) begin
                    bad++;
                    $display("FAIL b8_latency got en=%b want 1", wbif.fm_wr_en);
                end
            end
            if (i == 9) begin
                total++;
                if ({wbif.fm_wr_en, wbif.fm_wr_addr} !== {1'b0, 12'h010}) begin
                    bad++;
                    $display("FAIL b8_strobe_hold got en=%b addr=%h want en=0 addr=010",
                             wbif.fm_wr_en, wbif.fm_wr_addr);
                end
            end
        end
        pulse_finish();
        wait_done(seen);
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL b8_done got=0 want=1"); end
        total++;
        if (fa_q.size() !== 2) begin
            bad++; $display("FAIL b8_count got=%0d want=2", fa_q.size());
        end else begin
            total++;
            if ({fa_q[0], fd_q[0], fk_q[0]} !== {12'h010, 64'h0807060504030201, 8'hFF}) begin
                bad++;
                $display("FAIL b8_w0 got %h/%h/%h want 010/0807060504030201/ff", fa_q[0], fd_q[0], fk_q[0]);
            end
            total++;
            if ({fa_q[1], fd_q[1], fk_q[1]} !== {12'h011, 64'h100F0E0D0C0B0A09, 8'hFF}) begin
                bad++;
                $display("FAIL b8_w1 got %h/%h/%h want 011/100f0e0d0c0b0a09/ff", fa_q[1], fd_q[1], fk_q[1]);
            end
        end
        total++;
        if (ga_q.size() !== 0) begin bad++; $display("FAIL b8_no_guard got=%0d want=0", ga_q.size()); end
    endtask

    task automatic test_4bit();
        bit seen;
        clear_mon();
        do_start(12'h020, 10'h000);
        do_start(12'h3AA, 10'h155);  // RUN: must be ignored
        send_byte(8'h01, 1'b1, 1'b0);
        send_byte(8'h02, 1'b1, 1'b0);
        send_byte(8'h03, 1'b1, 1'b0);
        send_byte(8'h04, 1'b1, 1'b1);  // last value with finish in the same cycle
        wait_done(seen);
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL n4_done got=0 want=1"); end
        total++;
        if (fa_q.size() !== 1) begin
            bad++; $display("FAIL n4_count got=%0d want=1", fa_q.size());
        end else begin
            total++;
            if ({fa_q[0], fd_q[0], fk_q[0]} !== {12'h020, 64'h0000000000004321, 8'h03}) begin
                bad++;
                $display("FAIL n4_w0 got %h/%h/%h want 020/0000000000004321/03", fa_q[0], fd_q[0], fk_q[0]);
            end
        end
    endtask

    task automatic test_mixed();
        bit seen;
        clear_mon();
        do_start(12'h030, 10'h000);
        for (int i = 0; i < 7; i++) send_byte(8'h11 + 8'(i), 1'b0, 1'b0);
        send_byte(8'hFA, 1'b1, 1'b0);  // upper nibble must be dropped
        send_byte(8'h55, 1'b0, 1'b0);
        pulse_finish();
        wait_done(seen);
        total++;
        if (fa_q.size() !== 2) begin
            bad++; $display("FAIL mix_count got=%0d want=2", fa_q.size());
        end else begin
            total++;
            if ({fa_q[0], fd_q[0], fk_q[0]} !== {12'h030, 64'h0A17161514131211, 8'hFF}) begin
                bad++;
                $display("FAIL mix_w0 got %h/%h/%h want 030/0a17161514131211/ff", fa_q[0], fd_q[0], fk_q[0]);
            end
            total++;
            if ({fa_q[1], fd_q[1], fk_q[1]} !== {12'h031, 64'h0000000000000055, 8'h01}) begin
                bad++;
                $display("FAIL mix_w1 got %h/%h/%h want 031/0000000000000055/01", fa_q[1], fd_q[1], fk_q[1]);
            end
        end
    endtask

    task automatic test_guard();
        bit seen;
        clear_mon();
        do_start(12'h000, 10'h100);
        for (int i = 0; i < 10; i++) send_guard(6'h3F);
        pulse_finish();
        wait_done(seen);
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL g_done got=0 want=1"); end
        total++;
        if (ga_q.size() !== 2) begin
            bad++; $display("FAIL g_count got=%0d want=2", ga_q.size());
        end else begin
            total++;
            if ({ga_q[0], gd_q[0]} !== {10'h100, 48'hFFFF_FFFF_FFFF}) begin
                bad++; $display("FAIL g_w0 got %h/%h want 100/ffffffffffff", ga_q[0], gd_q[0]);
            end
            total++;
            if ({ga_q[1], gd_q[1]} !== {10'h101, 48'h0000_0000_0FFF}) begin
                bad++; $display("FAIL g_w1 got %h/%h want 101/000000000fff", ga_q[1], gd_q[1]);
            end
        end
        total++;
        if (fa_q.size() !== 0) begin bad++; $display("FAIL g_no_fm got=%0d want=0", fa_q.size()); end
    endtask

    task automatic test_wrap();
        bit seen;
        clear_mon();
        do_start(12'hFFF, 10'h000);
        for (int i = 0; i < 16; i++) send_byte(8'hA0 + 8'(i), 1'b0, 1'b0);
        pulse_finish();
        wait_done(seen);
        total++;
        if (fa_q.size() !== 2) begin
            bad++; $display("FAIL wrap_count got=%0d want=2", fa_q.size());
        end else begin
            total++;
            if ({fa_q[0], fd_q[0]} !== {12'hFFF, 64'hA7A6A5A4A3A2A1A0}) begin
                bad++; $display("FAIL wrap_w0 got %h/%h want fff/a7a6a5a4a3a2a1a0", fa_q[0], fd_q[0]);
            end
            total++;
            if ({fa_q[1], fd_q[1]} !== {12'h000, 64'hAFAEADACABAAA9A8}) begin
                bad++; $display("FAIL wrap_w1 got %h/%h want 000/afaeadacabaaa9a8", fa_q[1], fd_q[1]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        clear_mon();
        do_start(12'h040, 10'h040);
        send_byte(8'h31, 1'b0, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_guard(6'h15);
        send_guard(6'h2A);
        rst = 1'b1;
        #1;
        total++;
        if ({wbif.fm_wr_en, wbif.fm_wr_addr, wbif.fm_wr_data, wbif.fm_wr_mask,
             wbif.guard_wr_en, wbif.guard_wr_addr, wbif.guard_wr_data, wbif.done_o} !== '0) begin
            bad++;
            $display("FAIL rmid_outputs got fm=%h/%h/%h guard=%h/%h want all 0",
                     wbif.fm_wr_addr, wbif.fm_wr_data, wbif.fm_wr_mask,
                     wbif.guard_wr_addr, wbif.guard_wr_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ((fa_q.size() + ga_q.size()) !== 0) begin
            bad++; $display("FAIL rmid_no_write got=%0d want=0", fa_q.size() + ga_q.size());
        end
        clear_mon();
        do_start(12'h050, 10'h020);
        for (int i = 0; i < 8; i++) send_byte(8'hC0 + 8'(i), 1'b0, 1'b0);
        pulse_finish();
        wait_done(seen);
        total++;
        if (seen !== 1'b1) begin bad++; $display("FAIL rmid_done got=0 want=1"); end
        total++;
        if (fa_q.size() !== 1) begin
            bad++; $display("FAIL rmid_count got=%0d want=1", fa_q.size());
        end else begin
            total++;
            if ({fa_q[0], fd_q[0], fk_q[0]} !== {12'h050, 64'hC7C6C5C4C3C2C1C0, 8'hFF}) begin
                bad++;
                $display("FAIL rmid_w0 got %h/%h/%h want 050/c7c6c5c4c3c2c1c0/ff", fa_q[0], fd_q[0], fk_q[0]);
            end
        end
        total++;
        if (ga_q.size() !== 0) begin bad++; $display("FAIL rmid_no_guard got=%0d want=0", ga_q.size()); end
    endtask

    initial begin
        rst                = 1'b1;
        wbif.start_i       = 1'b0;
        wbif.fm_base_i     = '0;
        wbif.guard_base_i  = '0;
        wbif.data_i        = '0;
        wbif.data_i_valid  = 1'b0;
        wbif.bit_mode_i    = 1'b0;
        wbif.guard_i       = '0;
        wbif.guard_i_valid = 1'b0;
        wbif.finish_i      = 1'b0;

        test_reset();
        test_8bit();
        test_4bit();
        test_mixed();
        test_guard();
        test_wrap();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
